// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite renderer.
// Display geometry and default palette conventions live here.
package sprite_pkg;

    typedef enum logic {
        IDLE,
        PLAY
    } anim_state_t;

    localparam int COLOR_W        = 4;
    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int TRANSP_DEFAULT = 0;

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation frame sequencer: holds each frame for HOLD_FRAMES screen
// frames, then advances; one-shot returns to IDLE, loop wraps to 0.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES  = 4,
    parameter int HOLD_FRAMES = 6,
    parameter int FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               anim_start,
    input  logic               anim_loop,
    output logic [FRAME_W-1:0] frame,
    output logic               anim_busy
);

    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    anim_state_t       state;
    logic [HOLD_W-1:0] hold;

    // A start pulse beats a coincident tick, so restart always lands on hold 0.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            frame     <= '0;
            hold      <= '0;
            anim_busy <= 1'b0;
        end else if (anim_start) begin
            state     <= PLAY;
            frame     <= '0;
            hold      <= '0;
            anim_busy <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    frame <= '0;
                    hold  <= '0;
                end
                PLAY: begin
                    if (frame_tick) begin
                        if (hold == HOLD_W'(HOLD_FRAMES - 1)) begin
                            hold <= '0;
                            if (frame == FRAME_W'(NUM_FRAMES - 1)) begin
                                frame <= '0;
                                if (!anim_loop) begin
                                    state     <= IDLE;
                                    anim_busy <= 1'b0;
                                end
                            end else begin
                                frame <= frame + 1'b1;
                            end
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    anim_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Draws one scaled, flippable, animated sprite window between the VGA
// controller and colour mapper; fixed 3-cycle DrawX-to-RGB latency.
module sprite_anim_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int NUM_FRAMES  = 4,
    parameter int SCALE_LOG2  = 1,
    parameter int HOLD_FRAMES = 6,
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = TRANSP_DEFAULT,
    parameter int ADDR_W      = $clog2(NUM_FRAMES * SPR_W * SPR_H)
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_tick,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               flip,
    input  logic               anim_start,
    input  logic               anim_loop,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    input  logic [COLOR_W-1:0] pal_r,
    input  logic [COLOR_W-1:0] pal_g,
    input  logic [COLOR_W-1:0] pal_b,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               sprite_on,
    output logic               anim_busy
);

    localparam int COL_W   = $clog2(SPR_W);
    localparam int ROW_W   = $clog2(SPR_H);
    localparam int WIN_W   = SPR_W << SCALE_LOG2;
    localparam int WIN_H   = SPR_H << SCALE_LOG2;
    localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic [9:0]         px;
    logic [9:0]         py;
    logic               flp;
    logic [FRAME_W-1:0] frame;
    logic [10:0]        dx;
    logic [10:0]        dy;
    logic               hit;
    logic [COL_W-1:0]   col_raw;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr_next;
    logic               v1;
    logic               v2;
    logic               opaque;

    sprite_anim_seq #(
        .NUM_FRAMES  (NUM_FRAMES),
        .HOLD_FRAMES (HOLD_FRAMES),
        .FRAME_W     (FRAME_W)
    ) u_seq (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .anim_start (anim_start),
        .anim_loop  (anim_loop),
        .frame      (frame),
        .anim_busy  (anim_busy)
    );

    // 11-bit offsets: pixels left/above the window wrap huge and miss.
    assign dx      = {1'b0, DrawX} - {1'b0, px};
    assign dy      = {1'b0, DrawY} - {1'b0, py};
    assign hit     = (dx < 11'(WIN_W)) && (dy < 11'(WIN_H));
    assign col_raw = COL_W'(dx >> SCALE_LOG2);
    assign row     = ROW_W'(dy >> SCALE_LOG2);
    assign col     = flp ? ~col_raw : col_raw;

    assign addr_next = (ADDR_W'(frame) << (ROW_W + COL_W))
                     | ADDR_W'({row, col});

    assign opaque = v2 && (rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            px        <= '0;
            py        <= '0;
            flp       <= 1'b0;
            rom_addr  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            sprite_on <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            if (frame_tick) begin
                px  <= pos_x;
                py  <= pos_y;
                flp <= flip;
            end
            if (hit) begin
                rom_addr <= addr_next;
            end
            v1        <= hit & blank;
            v2        <= v1;
            sprite_on <= opaque;
            red       <= opaque ? pal_r : '0;
            green     <= opaque ? pal_g : '0;
            blue      <= opaque ? pal_b : '0;
        end
    end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Scoreboard bench for sprite_anim_renderer with a behavioural ROM,
// palette and animation model.
module tb_sprite_anim_renderer;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        flip = 1'b0;
    logic        anim_start = 1'b0;
    logic        anim_loop = 1'b0;
    logic [13:0] rom_addr;
    logic [3:0]  rom_q = '0;
    logic [3:0]  pal_r, pal_g, pal_b;
    logic [3:0]  red, green, blue;
    logic        sprite_on;
    logic        anim_busy;

    typedef struct {
        logic        on;
        logic [11:0] rgb;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_px, m_py, m_cnt;
    bit          m_flip, m_busy;
    logic [13:0] m_addr;

    sprite_anim_renderer dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .flip       (flip),
        .anim_start (anim_start),
        .anim_loop  (anim_loop),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pal_r      (pal_r),
        .pal_g      (pal_g),
        .pal_b      (pal_b),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .sprite_on  (sprite_on),
        .anim_busy  (anim_busy)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] rom_fn(logic [13:0] a);
        return a[3:0] + {2'b00, a[13:12]} + 4'd5;
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);

    assign pal_r = rom_q;
    assign pal_g = ~rom_q;
    assign pal_b = rom_q + 4'd1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        exp_t        e;
        int          dx, dy, col, row;
        bit          hit;
        logic [13:0] a;
        logic [3:0]  idx;
        dx  = int'(DrawX) - m_px;
        dy  = int'(DrawY) - m_py;
        hit = (dx >= 0) && (dx < 128) && (dy >= 0) && (dy < 128);
        col = dx / 2;
        row = dy / 2;
        if (m_flip) col = 63 - col;
        a     = 14'((m_cnt / 6) * 4096 + row * 64 + col);
        idx   = rom_fn(a);
        e.on  = hit && blank && (idx != 4'd0);
        e.rgb = e.on ? {idx, ~idx, idx + 4'd1} : 12'h000;
        sbq.push_back(e);
        @(posedge vga_clk);
        if (hit) m_addr = a;
        if (frame_tick) begin
            m_px   = int'(pos_x);
            m_py   = int'(pos_y);
            m_flip = flip;
        end
        if (anim_start) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy && frame_tick) begin
            m_cnt++;
            if (m_cnt == 24) begin
                m_cnt = 0;
                if (!anim_loop) m_busy = 1'b0;
            end
        end
        #1;
        e = sbq.pop_front();
        chk("sprite_on", 32'(sprite_on), 32'(e.on));
        chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("anim_busy", 32'(anim_busy), 32'(m_busy));
        @(negedge vga_clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pix(int x, int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
    endtask

    task automatic do_reset();
        exp_t z;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_sprite_on", 32'(sprite_on), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_anim_busy", 32'(anim_busy), 32'd0);
        sbq.delete();
        m_px = 0; m_py = 0; m_flip = 1'b0;
        m_cnt = 0; m_busy = 1'b0; m_addr = '0;
        @(negedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
        z.on  = 1'b0;
        z.rgb = 12'h000;
        sbq.push_back(z);
        sbq.push_back(z);
    endtask

    initial begin
        @(negedge vga_clk);
        do_reset();
        step();
        step();

        pos_x = 10'd100;
        pos_y = 10'd50;
        tick();
        blank = 1'b1;
        for (int x = 96; x < 136; x++) pix(x, 50);
        for (int x = 98; x < 104; x++) pix(x, 51);
        for (int x = 100; x < 104; x++) pix(x, 177);
        for (int x = 226; x < 230; x++) pix(x, 178);

        for (int x = 100; x < 106; x++) pix(x, 60);
        do_reset();
        for (int x = 0; x < 8; x++) pix(x, 0);
        pos_x = 10'd100;
        pos_y = 10'd50;
        tick();

        flip = 1'b1;
        tick();
        pix(100, 50);
        flip = 1'b0;
        pix(100, 50);
        pix(102, 50);
        pix(227, 51);

        pos_x = 10'd600;
        pos_y = 10'd450;
        tick();
        for (int x = 636; x < 640; x++) pix(x, 479);
        for (int x = 0; x < 4; x++) pix(x, 479);
        pix(620, 0);
        blank = 1'b0;
        pix(620, 460);
        pix(639, 479);
        blank = 1'b1;

        pos_x = 10'd100;
        pos_y = 10'd50;
        tick();
        DrawX = 10'd100;
        DrawY = 10'd50;
        anim_loop  = 1'b0;
        anim_start = 1'b1;
        step();
        anim_start = 1'b0;
        repeat (26) begin
            tick();
            step();
        end

        anim_loop  = 1'b1;
        anim_start = 1'b1;
        step();
        anim_start = 1'b0;
        repeat (27) tick();
        step();

        repeat (8) tick();
        anim_start = 1'b1;
        frame_tick = 1'b1;
        step();
        anim_start = 1'b0;
        frame_tick = 1'b0;
        step();
        repeat (7) tick();
        anim_loop = 1'b0;
        repeat (20) tick();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
